// File: rtl/bright_pwm_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bright_pwm_ctrl_if : sensor-value in, filtered value / duty / PWM out
// Rev 1.0
// ----------------------------------------------------------------------------
interface bright_pwm_ctrl_if;
   logic [11:0] I_bright_data;
   logic [11:0] O_filt_data;
   logic [7:0]  O_duty;
   logic        O_pwm;

   modport master (
      output I_bright_data,
      input  O_filt_data,
      input  O_duty,
      input  O_pwm
   );

   modport slave (
      input  I_bright_data,
      output O_filt_data,
      output O_duty,
      output O_pwm
   );
endinterface
`default_nettype wire

// File: rtl/bright_pwm_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bright_pwm_ctrl : ALS low-pass filter -> hysteretic duty map -> slewed PWM
// Rev 1.0
// ----------------------------------------------------------------------------
module bright_pwm_ctrl #(
   parameter int SAMPLE_DIV = 50000,
   parameter int FILT_SHIFT = 3,
   parameter int HYST       = 4,
   parameter int RAMP_DIV   = 50000,
   parameter int DUTY_MIN   = 16,
   parameter int DUTY_MAX   = 255
) (
   input  wire logic        I_clk,
   input  wire logic        I_reset,
   bright_pwm_ctrl_if.slave bus
);

   localparam int SW = $clog2(SAMPLE_DIV);
   localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int AW = 12 + FILT_SHIFT;
   localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);
   localparam logic [RW-1:0] RAMP_LAST   = RW'(RAMP_DIV - 1);
   localparam logic [7:0]    DMIN        = 8'(DUTY_MIN);
   localparam logic [15:0]   SPAN        = 16'(DUTY_MAX - DUTY_MIN + 1);
   localparam logic [8:0]    HYST9       = 9'(HYST);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILT = 2'd1,
      S_MAP  = 2'd2,
      S_CMP  = 2'd3
   } state_t;

   // Input synchroniser
   logic [11:0] sync1_q, sync2_q;

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= bus.I_bright_data;
         sync2_q <= sync1_q;
      end
   end

   // Sample and ramp tick dividers
   logic [SW-1:0] scnt_q;
   logic [RW-1:0] rcnt_q;
   logic          w_stick, w_rtick;

   assign w_stick = (scnt_q == SAMPLE_LAST);
   assign w_rtick = (rcnt_q == RAMP_LAST);

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         scnt_q <= '0;
         rcnt_q <= '0;
      end else begin
         scnt_q <= w_stick ? '0 : scnt_q + SW'(1);
         rcnt_q <= w_rtick ? '0 : rcnt_q + RW'(1);
      end
   end

   // Filter / map / compare datapath
   state_t      state_q;
   logic [11:0] x_q, filt_q, filt_d;
   logic [AW-1:0] acc_q, acc_d;
   logic        seed_q, seed_cyc_q;
   logic [7:0]  map_q, map_d, target_q;
   logic [15:0] w_prod;
   logic [8:0]  w_diff;

   // The true result always fits in AW bits, so modular arithmetic is exact.
   always_comb begin
      acc_d  = seed_q ? (AW'(x_q) << FILT_SHIFT)
                      : acc_q + AW'(x_q) - (acc_q >> FILT_SHIFT);
      filt_d = 12'(acc_d >> FILT_SHIFT);
   end

   assign w_prod = 16'(filt_q[11:4]) * SPAN;
   assign map_d  = DMIN + 8'(w_prod >> 8);
   assign w_diff = (map_q >= target_q) ? ({1'b0, map_q} - {1'b0, target_q})
                                       : ({1'b0, target_q} - {1'b0, map_q});

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         state_q    <= S_IDLE;
         x_q        <= '0;
         acc_q      <= '0;
         seed_q     <= 1'b1;
         seed_cyc_q <= 1'b0;
         filt_q     <= '0;
         map_q      <= DMIN;
         target_q   <= DMIN;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_stick) begin
                  x_q     <= sync2_q;
                  state_q <= S_FILT;
               end
            end
            S_FILT: begin
               acc_q      <= acc_d;
               filt_q     <= filt_d;
               seed_cyc_q <= seed_q;
               seed_q     <= 1'b0;
               state_q    <= S_MAP;
            end
            S_MAP: begin
               map_q   <= map_d;
               state_q <= S_CMP;
            end
            S_CMP: begin
               if (seed_cyc_q || (w_diff > HYST9)) begin
                  target_q <= map_q;
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Slew limiter; sees the pre-update target when a CMP lands on the same edge
   logic [7:0] duty_q;

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         duty_q <= DMIN;
      end else if (w_rtick) begin
         if (duty_q < target_q) begin
            duty_q <= duty_q + 8'd1;
         end else if (duty_q > target_q) begin
            duty_q <= duty_q - 8'd1;
         end
      end
   end

   // PWM generator; duty is only picked up at the period boundary
   logic [7:0] pcnt_q, applied_q;
   logic       pwm_q;

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         pcnt_q    <= '0;
         applied_q <= '0;
         pwm_q     <= 1'b0;
      end else begin
         pcnt_q <= pcnt_q + 8'd1;
         if (pcnt_q == 8'hFF) begin
            applied_q <= duty_q;
         end
         pwm_q <= (applied_q == 8'hFF) || (pcnt_q < applied_q);
      end
   end

   assign bus.O_filt_data = filt_q;
   assign bus.O_duty      = duty_q;
   assign bus.O_pwm       = pwm_q;

endmodule
`default_nettype wire
